// File: rtl/ram_stream_reader.sv
// Sequential read engine for the simple dual-port RAM read port: walks addresses with enb/addrb
// and turns the 1-cycle-latency doutb into a valid/ready stream through a 3-entry FIFO.
module ram_stream_reader #(
    parameter int unsigned RAM_WIDTH      = 64,
    parameter int unsigned RAM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [RAM_ADDR_WIDTH:0]   len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      enb_o,
    output logic [RAM_ADDR_WIDTH-1:0] addrb_o,
    input  logic [RAM_WIDTH-1:0]      doutb_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [RAM_WIDTH-1:0]      m_data_o,
    output logic                      m_last_o
);

    localparam int unsigned Depth = 3;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [RAM_ADDR_WIDTH:0]   LenOne  = (RAM_ADDR_WIDTH+1)'(1);
    localparam logic [RAM_ADDR_WIDTH-1:0] AddrOne = RAM_ADDR_WIDTH'(1);

    logic [1:0]                state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [RAM_ADDR_WIDTH:0]   issue_left_q, issue_left_d;
    logic [RAM_ADDR_WIDTH:0]   pop_left_q, pop_left_d;
    logic                      inflight_q, inflight_d;
    logic                      done_q, done_d;
    logic [RAM_WIDTH-1:0]      mem_q [Depth];
    logic [1:0]                wr_ptr_q, wr_ptr_d;
    logic [1:0]                rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic [2:0]                occupancy;
    logic                      issue;
    logic                      push;
    logic                      pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue depends only on registered state so m_ready never reaches enb combinationally.
    always_comb begin
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        issue     = (state_q == StRun) && (occupancy < 3'd3);
        push      = inflight_q;
        pop       = (count_q != 2'd0) && m_ready_i;
    end

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        done_d       = 1'b0;
        inflight_d   = issue;
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};

        if (issue) begin
            rd_addr_d    = rd_addr_q + AddrOne;
            issue_left_d = issue_left_q - LenOne;
        end
        if (pop) begin
            pop_left_d = pop_left_q - LenOne;
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = StRun;
                        rd_addr_d    = base_addr_i;
                        issue_left_d = len_i;
                        pop_left_d   = len_i;
                    end
                end
            end
            StRun: begin
                if (issue && (issue_left_q == LenOne)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && (pop_left_q == LenOne)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rd_addr_q    <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= doutb_i;
            end
        end
    end

    assign busy_o    = (state_q != StIdle) || done_q;
    assign done_o    = done_q;
    assign enb_o     = issue;
    assign addrb_o   = rd_addr_q;
    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = mem_q[rd_ptr_q];
    assign m_last_o  = (pop_left_q == LenOne);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: behavioural RAM, address and data scoreboards,
// stall-stability and occupancy monitors, directed job sequences.
module tb_ram_stream_reader;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [9:0]  base_addr_i;
    logic [10:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        enb_o;
    logic [9:0]  addrb_o;
    logic [63:0] doutb_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [63:0] m_data_o;
    logic        m_last_o;

    logic [63:0] ram [1024];
    exp_t        exp_q[$];
    logic [9:0]  addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int outstanding = 0;
    bit bp_mode  = 0;
    int pat_idx  = 0;
    bit bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    bit          prev_stall = 0;
    logic [63:0] prev_data;
    logic        prev_last;
    exp_t        e_mon;
    logic [9:0]  a_mon;
    logic        hs;

    ram_stream_reader #(
        .RAM_WIDTH      (64),
        .RAM_ADDR_WIDTH (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .enb_o       (enb_o),
        .addrb_o     (addrb_o),
        .doutb_i     (doutb_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 64'(i) + 64'h100;
        doutb_i = '0;
    end

    always @(posedge clk) begin
        if (enb_o) doutb_i <= ram[addrb_o];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) begin
            m_ready_i = bp_pat[pat_idx % 6];
            pat_idx++;
        end
    endtask

    task automatic start_job(input logic [10:0] len, input logic [9:0] base, input bit accept);
        exp_t       e;
        logic [9:0] a;
        start_i     = 1'b1;
        base_addr_i = base;
        len_i       = len;
        if (accept) begin
            n_pops = 0;
            for (int i = 0; i < int'(len); i++) begin
                a      = base + 10'(i);
                e.data = 64'(a) + 64'h100;
                e.last = (i == int'(len) - 1);
                addr_q.push_back(a);
                exp_q.push_back(e);
            end
        end
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (!done_o && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        check_eq("done_seen", done_o, 1);
        check_eq("busy_at_done", busy_o, 1);
        tick();
        check_eq("done_one_cycle", done_o, 0);
        check_eq("busy_after_done", busy_o, 0);
        check_eq("sb_empty", 64'(exp_q.size()), 0);
        check_eq("addr_q_empty", 64'(addr_q.size()), 0);
    endtask

    // Monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall  = 0;
            outstanding = 0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", m_valid_o, 1);
                check_eq("stall_data", m_data_o, prev_data);
                check_eq("stall_last", m_last_o, prev_last);
            end
            if (enb_o) begin
                check_eq("occ_lt3", (outstanding < 3), 1);
                if (addr_q.size() == 0) begin
                    check_eq("addr_extra", 1, 0);
                end else begin
                    a_mon = addr_q.pop_front();
                    check_eq("addrb", addrb_o, a_mon);
                end
            end
            hs = m_valid_o && m_ready_i;
            if (hs) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    check_eq("sb_extra", 1, 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check_eq("m_data", m_data_o, e_mon.data);
                    check_eq("m_last", m_last_o, e_mon.last);
                end
            end
            prev_stall  = m_valid_o && !m_ready_i;
            prev_data   = m_data_o;
            prev_last   = m_last_o;
            outstanding = outstanding + int'(enb_o) - int'(hs);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        len_i       = '0;
        m_ready_i   = 1'b1;
        #1;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_enb", enb_o, 0);
        check_eq("rst_valid", m_valid_o, 0);
        check_eq("rst_last", m_last_o, 0);
        check_eq("rst_addrb", addrb_o, 0);
        check_eq("rst_data", m_data_o, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic run
        start_job(11'd4, 10'd5, 1);
        check_eq("basic_busy", busy_o, 1);
        check_eq("basic_enb", enb_o, 1);
        check_eq("basic_addrb0", addrb_o, 5);
        check_eq("basic_valid_e0", m_valid_o, 0);
        tick();
        check_eq("basic_valid_e1", m_valid_o, 0);
        tick();
        check_eq("basic_valid_e2", m_valid_o, 1);
        check_eq("basic_first", m_data_o, 64'h105);
        wait_done(50, cyc);
        check_eq("basic_done_lat", 64'(cyc), 4);
        check_eq("basic_pops", 64'(n_pops), 4);

        // Backpressure
        bp_mode   = 1;
        pat_idx   = 1;
        m_ready_i = bp_pat[0];
        start_job(11'd8, 10'd300, 1);
        wait_done(100, cyc);
        check_eq("bp_pops", 64'(n_pops), 8);
        bp_mode   = 0;
        m_ready_i = 1'b1;
        tick();

        // Address wrap
        start_job(11'd4, 10'd1022, 1);
        wait_done(50, cyc);
        check_eq("wrap_pops", 64'(n_pops), 4);

        // Zero length
        start_job(11'd0, 10'd7, 1);
        check_eq("zero_done", done_o, 1);
        check_eq("zero_busy", busy_o, 1);
        check_eq("zero_enb", enb_o, 0);
        tick();
        check_eq("zero_done_off", done_o, 0);
        check_eq("zero_busy_off", busy_o, 0);
        check_eq("zero_enb_off", enb_o, 0);
        tick();

        // Start while busy is ignored
        start_job(11'd3, 10'd40, 1);
        tick();
        start_job(11'd5, 10'd200, 0);
        wait_done(50, cyc);
        check_eq("ignored_pops", 64'(n_pops), 3);
        tick();

        // Reset mid-job with a read in flight
        start_job(11'd6, 10'd20, 1);
        tick();
        tick();
        tick();
        check_eq("mid_valid", m_valid_o, 1);
        check_eq("mid_word2", m_data_o, 64'h115);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        addr_q.delete();
        check_eq("abort_busy", busy_o, 0);
        check_eq("abort_done", done_o, 0);
        check_eq("abort_enb", enb_o, 0);
        check_eq("abort_valid", m_valid_o, 0);
        check_eq("abort_last", m_last_o, 0);
        check_eq("abort_addrb", addrb_o, 0);
        check_eq("abort_data", m_data_o, 0);
        tick();
        check_eq("abort_done_hold", done_o, 0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_done", done_o, 0);
        check_eq("post_rst_busy", busy_o, 0);
        start_job(11'd2, 10'd100, 1);
        wait_done(50, cyc);
        check_eq("post_rst_pops", 64'(n_pops), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
